// File: rtl/fifo_drain_packer.sv
// fifo_drain_packer
//
// Drains bytes from an upstream byte FIFO and packs them into 32-bit
// little-endian words for a valid/ready downstream port. A full word is
// emitted as soon as four bytes are assembled. A partial word is emitted
// with a matching lane-enable mask when a flush is requested, either by the
// flush_i pulse or by the assembly sitting idle for TIMEOUT cycles.
//
// Ports
//   clk_i         single clock, all state updates on the rising edge
//   rst_i         asynchronous active-high reset
//   fifo_empty_i  upstream FIFO empty flag
//   fifo_rd_o     upstream read strobe (combinational), one byte per cycle
//   fifo_dout_i   upstream read data, valid the cycle after fifo_rd_o
//   flush_i       single-cycle request to emit the current partial word
//   word_data_o   packed word, byte 0 in [7:0]
//   word_be_o     lane enables, bit n covers word_data_o[8n+7:8n]
//   word_valid_o  word_data_o/word_be_o hold a word
//   word_ready_i  downstream accepts when word_valid_o && word_ready_i
module fifo_drain_packer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fifo_empty_i,
    output logic        fifo_rd_o,
    input  logic [7:0]  fifo_dout_i,
    input  logic        flush_i,
    output logic [31:0] word_data_o,
    output logic [3:0]  word_be_o,
    output logic        word_valid_o,
    input  logic        word_ready_i
);

    // Idle counter saturates at TIMEOUT; flush fires on the TIMEOUT-th idle cycle.
    localparam logic [7:0] TIMEOUT_CAP  = 8'(TIMEOUT);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    // Assembly state
    logic [31:0] lanes_q,     lanes_d;
    logic [2:0]  fill_q,      fill_d;
    logic        pend_q;
    logic        flush_req_q, flush_req_d;
    logic [7:0]  idle_q,      idle_d;

    // Output register
    logic [31:0] word_data_q,  word_data_d;
    logic [3:0]  word_be_q,    word_be_d;
    logic        word_valid_q, word_valid_d;

    // Combinational helpers
    logic        out_free_s;
    logic [2:0]  occ_s;
    logic        full_s;
    logic        partial_s;
    logic        idle_cond_s;
    logic        timeout_s;
    logic        rd_s;
    logic [31:0] merged_s;
    logic [3:0]  part_be_s;
    logic [31:0] part_mask_s;

    // Transfer conditions and read strobe.
    always_comb begin
        out_free_s = !word_valid_q || word_ready_i;
        // Occupancy counts the byte in flight so the lanes can never overflow.
        occ_s      = fill_q + {2'b00, pend_q};
        // A full transfer may complete on the same edge the fourth byte is
        // captured; the in-flight byte is merged straight into the word.
        full_s     = (occ_s == 3'd4) && out_free_s;
        partial_s  = flush_req_q && !pend_q && (fill_q >= 3'd1) &&
                     (fill_q <= 3'd3) && out_free_s;
        // When a full transfer empties the lanes this cycle, the next byte can
        // already be requested; this keeps the strobe continuously high at
        // one word per four cycles.
        rd_s       = !rst_i && !fifo_empty_i && !flush_req_q &&
                     ((occ_s < 3'd4) || full_s);
        idle_cond_s = !pend_q && (fill_q >= 3'd1) && (fill_q <= 3'd3);
        timeout_s   = idle_cond_s && (idle_q == TIMEOUT_LAST);
    end

    assign fifo_rd_o = rd_s;

    // Lane view with the in-flight byte placed at lane[fill].
    always_comb begin
        merged_s = lanes_q;
        if (pend_q) begin
            merged_s[{fill_q[1:0], 3'b000} +: 8] = fifo_dout_i;
        end else begin
            merged_s = lanes_q;
        end
    end

    // Lane-enable mask and data mask for a partial word.
    always_comb begin
        case (fill_q)
            3'd1:    part_be_s = 4'b0001;
            3'd2:    part_be_s = 4'b0011;
            3'd3:    part_be_s = 4'b0111;
            default: part_be_s = 4'b0000;
        endcase
        part_mask_s = 32'h0000_0000;
        for (int i = 0; i < 4; i++) begin
            part_mask_s[i*8 +: 8] = {8{part_be_s[i]}};
        end
    end

    // Next-state for the assembly register, fill count and idle counter.
    always_comb begin
        lanes_d = lanes_q;
        fill_d  = fill_q;
        idle_d  = idle_q;
        if (full_s || partial_s) begin
            // Any in-flight byte is already merged into the full word, and a
            // partial transfer only happens with nothing in flight.
            lanes_d = 32'h0000_0000;
            fill_d  = 3'd0;
        end else if (pend_q) begin
            lanes_d = merged_s;
            fill_d  = fill_q + 3'd1;
        end else begin
            lanes_d = lanes_q;
            fill_d  = fill_q;
        end

        if (!idle_cond_s) begin
            idle_d = 8'd0;
        end else if (idle_q != TIMEOUT_CAP) begin
            idle_d = idle_q + 8'd1;
        end else begin
            idle_d = idle_q;
        end
    end

    // Sticky flush request.
    always_comb begin
        flush_req_d = flush_req_q;
        if (full_s || partial_s) begin
            flush_req_d = 1'b0;
        end else if (timeout_s || (flush_i && ((fill_q != 3'd0) || pend_q))) begin
            flush_req_d = 1'b1;
        end else if ((fill_q == 3'd0) && !pend_q) begin
            // Nothing left to flush; never let a stale request block reads.
            flush_req_d = 1'b0;
        end else begin
            flush_req_d = flush_req_q;
        end
    end

    // Output register load / release.
    always_comb begin
        word_data_d  = word_data_q;
        word_be_d    = word_be_q;
        word_valid_d = word_valid_q;
        if (full_s) begin
            word_data_d  = merged_s;
            word_be_d    = 4'b1111;
            word_valid_d = 1'b1;
        end else if (partial_s) begin
            word_data_d  = lanes_q & part_mask_s;
            word_be_d    = part_be_s;
            word_valid_d = 1'b1;
        end else if (word_valid_q && word_ready_i) begin
            word_valid_d = 1'b0;
        end else begin
            word_valid_d = word_valid_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lanes_q      <= 32'h0000_0000;
            fill_q       <= 3'd0;
            pend_q       <= 1'b0;
            flush_req_q  <= 1'b0;
            idle_q       <= 8'd0;
            word_data_q  <= 32'h0000_0000;
            word_be_q    <= 4'b0000;
            word_valid_q <= 1'b0;
        end else begin
            lanes_q      <= lanes_d;
            fill_q       <= fill_d;
            pend_q       <= rd_s;
            flush_req_q  <= flush_req_d;
            idle_q       <= idle_d;
            word_data_q  <= word_data_d;
            word_be_q    <= word_be_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign word_data_o  = word_data_q;
    assign word_be_o    = word_be_q;
    assign word_valid_o = word_valid_q;

endmodule

// File: tb/tb_fifo_drain_packer.sv
// Testbench for fifo_drain_packer: an upstream FIFO model feeds bytes, and a
// scoreboard of expected words is checked whenever the DUT hands one over.
module tb_fifo_drain_packer;

    logic        clk;
    logic        rst;
    logic        fifo_empty;
    logic        fifo_rd;
    logic [7:0]  fifo_dout;
    logic        flush;
    logic [31:0] word_data;
    logic [3:0]  word_be;
    logic        word_valid;
    logic        word_ready;

    logic [7:0]  src_q[$];
    logic [35:0] exp_q[$];

    int total;
    int bad;
    int cyc;
    int rd_cnt;
    int valid_cnt;
    int first_valid_cyc;
    logic        held_v;
    logic [31:0] held_data;
    logic [3:0]  held_be;

    fifo_drain_packer #(.TIMEOUT(16)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .fifo_empty_i (fifo_empty),
        .fifo_rd_o    (fifo_rd),
        .fifo_dout_i  (fifo_dout),
        .flush_i      (flush),
        .word_data_o  (word_data),
        .word_be_o    (word_be),
        .word_valid_o (word_valid),
        .word_ready_i (word_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic clear_counters();
        cyc = 0;
        rd_cnt = 0;
        valid_cnt = 0;
        first_valid_cyc = -1;
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic cycle();
        logic       rd_now;
        logic [35:0] e;
        fifo_empty = (src_q.size() == 0);
        #1;
        rd_now = fifo_rd;
        if (rd_now) rd_cnt++;
        if (word_valid) begin
            valid_cnt++;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end
        if (held_v) begin
            total++;
            if (word_valid !== 1'b1 || word_data !== held_data || word_be !== held_be) begin
                bad++;
                $display("FAIL hold_stable: got v=%b data=%h be=%b, need v=1 data=%h be=%b",
                         word_valid, word_data, word_be, held_data, held_be);
            end
        end
        held_v    = word_valid && !word_ready;
        held_data = word_data;
        held_be   = word_be;
        if (word_valid && word_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_word: got data=%h be=%b, need no word", word_data, word_be);
            end else begin
                e = exp_q.pop_front();
                if (word_data !== e[31:0] || word_be !== e[35:32]) begin
                    bad++;
                    $display("FAIL word: got data=%h be=%b, need data=%h be=%b",
                             word_data, word_be, e[31:0], e[35:32]);
                end
            end
        end
        @(posedge clk);
        #1;
        if (rd_now) begin
            if (src_q.size() > 0) fifo_dout = src_q.pop_front();
            else fifo_dout = 8'h00;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic drain(input int max_cyc, input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            cycle();
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: got %0d words outstanding, need 0", name, exp_q.size());
        end
    endtask

    task automatic check_int(input string name, input int got, input int need);
        total++;
        if (got !== need) begin
            bad++;
            $display("FAIL %s: got %0d, need %0d", name, got, need);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        fifo_empty = 1'b0;
        @(negedge clk);
        #1;
        total++;
        if (fifo_rd !== 1'b0 || word_valid !== 1'b0 || word_data !== 32'h0 || word_be !== 4'h0) begin
            bad++;
            $display("FAIL reset_outputs: got rd=%b v=%b data=%h be=%b, need all 0",
                     fifo_rd, word_valid, word_data, word_be);
        end
        fifo_empty = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_full_word();
        clear_counters();
        word_ready = 1'b1;
        src_q.push_back(8'h11); src_q.push_back(8'h22);
        src_q.push_back(8'h33); src_q.push_back(8'h44);
        exp_q.push_back({4'hF, 32'h44332211});
        run(12);
        check_int("full_rd_pulses", rd_cnt, 4);
        check_int("full_valid_cycles", valid_cnt, 1);
        check_int("full_outstanding", exp_q.size(), 0);
    endtask

    task automatic test_timeout();
        clear_counters();
        word_ready = 1'b1;
        src_q.push_back(8'hAA); src_q.push_back(8'hBB);
        exp_q.push_back({4'b0011, 32'h0000BBAA});
        run(26);
        check_int("timeout_valid_cycle", first_valid_cyc, 20);
        check_int("timeout_valid_cycles", valid_cnt, 1);
        check_int("timeout_outstanding", exp_q.size(), 0);
    endtask

    task automatic test_backpressure();
        logic [31:0] w;
        clear_counters();
        word_ready = 1'b0;
        for (int i = 0; i < 12; i++) src_q.push_back(8'(8'h30 + i));
        for (int k = 0; k < 3; k++) begin
            w = {8'(8'h33 + 4*k), 8'(8'h32 + 4*k), 8'(8'h31 + 4*k), 8'(8'h30 + 4*k)};
            exp_q.push_back({4'hF, w});
        end
        run(10);
        check_int("bp_rd_pulses", rd_cnt, 8);
        #1;
        total++;
        if (fifo_rd !== 1'b0 || word_valid !== 1'b1 || word_data !== 32'h33323130) begin
            bad++;
            $display("FAIL bp_held: got rd=%b v=%b data=%h, need rd=0 v=1 data=33323130",
                     fifo_rd, word_valid, word_data);
        end
        word_ready = 1'b1;
        drain(40, "bp");
        check_int("bp_total_reads", rd_cnt, 12);
    endtask

    task automatic test_flush_pending();
        clear_counters();
        word_ready = 1'b1;
        src_q.push_back(8'h5A);
        exp_q.push_back({4'b0001, 32'h0000005A});
        cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        run(8);
        check_int("flushp_valid_cycle", first_valid_cyc, 3);
        check_int("flushp_valid_cycles", valid_cnt, 1);
        check_int("flushp_outstanding", exp_q.size(), 0);
    endtask

    task automatic test_flush_empty();
        clear_counters();
        word_ready = 1'b1;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        run(20);
        check_int("flush_empty_no_word", valid_cnt, 0);
        src_q.push_back(8'hC1); src_q.push_back(8'hC2);
        src_q.push_back(8'hC3); src_q.push_back(8'hC4);
        exp_q.push_back({4'hF, 32'hC4C3C2C1});
        drain(20, "flush_empty_after");
    endtask

    task automatic test_back_to_back();
        clear_counters();
        word_ready = 1'b1;
        for (int i = 0; i < 16; i++) src_q.push_back(8'(8'h80 + i));
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back({4'hF, 8'(8'h83 + 4*k), 8'(8'h82 + 4*k),
                                   8'(8'h81 + 4*k), 8'(8'h80 + 4*k)});
        end
        run(16);
        check_int("b2b_rd_continuous", rd_cnt, 16);
        drain(20, "b2b");
        check_int("b2b_valid_cycles", valid_cnt, 4);
    endtask

    task automatic test_reset_mid();
        clear_counters();
        word_ready = 1'b0;
        for (int i = 0; i < 7; i++) src_q.push_back(8'(8'h60 + i));
        run(10);
        src_q.push_back(8'h01); src_q.push_back(8'h02);
        src_q.push_back(8'h03); src_q.push_back(8'h04);
        fifo_empty = 1'b0;
        rst = 1'b1;
        #1;
        total++;
        if (fifo_rd !== 1'b0 || word_valid !== 1'b0 || word_data !== 32'h0 || word_be !== 4'h0) begin
            bad++;
            $display("FAIL reset_mid: got rd=%b v=%b data=%h be=%b, need all 0",
                     fifo_rd, word_valid, word_data, word_be);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        held_v = 1'b0;
        word_ready = 1'b1;
        exp_q.push_back({4'hF, 32'h04030201});
        drain(30, "reset_mid");
    endtask

    initial begin
        total = 0;
        bad = 0;
        held_v = 1'b0;
        held_data = 32'h0;
        held_be = 4'h0;
        rst = 1'b1;
        fifo_empty = 1'b1;
        fifo_dout = 8'h00;
        flush = 1'b0;
        word_ready = 1'b0;
        clear_counters();
        test_reset();
        test_full_word();
        test_timeout();
        test_backpressure();
        test_flush_pending();
        test_flush_empty();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
